// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial number transmitter.
// FSM state encoding plus the mod-5 remainder state values.
package serial_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    localparam logic [2:0] REM0 = 3'd0;
    localparam logic [2:0] REM1 = 3'd1;
    localparam logic [2:0] REM2 = 3'd2;
    localparam logic [2:0] REM3 = 3'd3;
    localparam logic [2:0] REM4 = 3'd4;

endpackage

// File: rtl/serial_mod5_step.sv
// Combinational mod-5 remainder step: rem_o = (2*rem_i + bit_i) mod 5.
// Only instantiated when SERIAL_TX_MOD5_EN is defined.
module serial_mod5_step
    import serial_tx_pkg::*;
(
    input  logic [2:0] rem_i,
    input  logic       bit_i,
    output logic [2:0] rem_o
);

    always_comb begin
        rem_o = REM0;
        case ({rem_i, bit_i})
            {REM0, 1'b0}: rem_o = REM0;
            {REM0, 1'b1}: rem_o = REM1;
            {REM1, 1'b0}: rem_o = REM2;
            {REM1, 1'b1}: rem_o = REM3;
            {REM2, 1'b0}: rem_o = REM4;
            {REM2, 1'b1}: rem_o = REM0;
            {REM3, 1'b0}: rem_o = REM1;
            {REM3, 1'b1}: rem_o = REM2;
            {REM4, 1'b0}: rem_o = REM3;
            {REM4, 1'b1}: rem_o = REM4;
            default:      rem_o = REM0;
        endcase
    end

endmodule

// File: rtl/serial_number_transmitter.sv
// MSB-first parallel-to-serial transmitter with valid/ready on both sides.
// Optional running mod-5 remainder of the sent bits: define SERIAL_TX_MOD5_EN.
module serial_number_transmitter
    import serial_tx_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         new_bit,
    output logic         out_last,
    output logic         done,
    output logic [2:0]   rem5,
    output logic         div_by_5
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;
    logic          done_q, done_d;

    logic in_xfer;
    logic out_xfer;
    logic last_bit;

    assign last_bit = (cnt_q == LAST_IDX);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) state_d = SEND;
            end
            SEND: begin
                // A word loaded on the last-bit transfer keeps us in SEND
                if (in_xfer)                   state_d = SEND;
                else if (out_xfer && last_bit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        new_bit   = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SEND: begin
                out_valid = 1'b1;
                new_bit   = sh_q[W-1];
                out_last  = last_bit;
                in_ready  = out_ready & last_bit;
            end
            default: ;
        endcase
    end

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        done_d = out_xfer & last_bit;
        if (in_xfer) begin
            sh_d  = in_data;
            cnt_d = '0;
        end else if (out_xfer) begin
            sh_d  = {sh_q[W-2:0], 1'b0};
            cnt_d = last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

`ifdef SERIAL_TX_MOD5_EN
    logic [2:0] rem_q, rem_d, rem_step;

    serial_mod5_step u_mod5_step (
        .rem_i (rem_q),
        .bit_i (new_bit),
        .rem_o (rem_step)
    );

    always_comb begin
        rem_d = rem_q;
        if (in_xfer)       rem_d = REM0;
        else if (out_xfer) rem_d = rem_step;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= REM0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem5     = rem_q;
    assign div_by_5 = (rem_q == REM0);
`else
    assign rem5     = '0;
    assign div_by_5 = 1'b1;
`endif

endmodule

// File: tb/tb_serial_number_transmitter.sv
// Self-checking bench: table vectors, random words vs. an arithmetic model,
// plus back-to-back and mid-word reset sequences.
module tb_serial_number_transmitter;

    localparam int W = 16;
`ifdef SERIAL_TX_MOD5_EN
    localparam bit MOD5 = 1'b1;
`else
    localparam bit MOD5 = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         new_bit;
    logic         out_last;
    logic         done;
    logic [2:0]   rem5;
    logic         div_by_5;

    int total = 0;
    int bad   = 0;

    serial_number_transmitter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .new_bit   (new_bit),
        .out_last  (out_last),
        .done      (done),
        .rem5      (rem5),
        .div_by_5  (div_by_5)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Remainder mod 5 of the first n bits of d, read MSB first.
    function automatic int prefix_rem(input logic [W-1:0] d, input int n);
        int v;
        if (!MOD5) return 0;
        v = int'({16'h0, d}) >> (W - n);
        return v % 5;
    endfunction

    function automatic int full_rem(input logic [W-1:0] d);
        if (!MOD5) return 0;
        return int'({16'h0, d}) % 5;
    endfunction

    task automatic check_rem(input string name, input int exp);
        check(name, 32'(rem5), 32'(exp));
        check({name, "_div5"}, 32'(div_by_5), 32'(exp == 0));
    endtask

    // Load d from IDLE, drain it under the given out_ready pattern, check done.
    task automatic run_word(input logic [W-1:0] d, input int stall_at, input int stall_len,
                            input int prob, input int exp_rem);
        int  i     = 0;
        int  stall = 0;
        int  guard = 0;
        logic r;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'($urandom_range(1));
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        while (i < W && guard < 400) begin
            guard++;
            if (stall_at >= 0 && i == stall_at && stall < stall_len) begin
                r = 1'b0;
                stall++;
            end else if (prob > 0) begin
                r = ($urandom_range(99) >= 32'(prob));
            end else begin
                r = 1'b1;
            end
            out_ready = r;
            in_valid  = (i < W - 1) ? 1'($urandom_range(1)) : 1'b0;
            in_data   = W'($urandom);
            #1;
            check("bit_valid", 32'(out_valid), 32'd1);
            check("bit_value", 32'(new_bit), 32'(d[W-1-i]));
            check("bit_last", 32'(out_last), 32'(i == W - 1));
            check("bit_in_ready", 32'(in_ready), 32'(r && i == W - 1));
            check("bit_done", 32'(done), 32'd0);
            check_rem("bit_rem", prefix_rem(d, i));
            if (r) i++;
            @(negedge clk);
        end
        check("word_timeout", 32'(i), 32'(W));
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(1));
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
        check_rem("done_rem", exp_rem);
        @(negedge clk);
        #1;
        check("done_clear", 32'(done), 32'd0);
        check_rem("idle_rem_hold", exp_rem);
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           stall_at;
        int           stall_len;
        int           rem;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [W-1:0] d;
        vecs[0] = '{data: 16'hA5A5, stall_at: -1, stall_len: 0, rem: 0};
        vecs[1] = '{data: 16'h0007, stall_at: -1, stall_len: 0, rem: 2};
        vecs[2] = '{data: 16'hFFFF, stall_at: 5,  stall_len: 3, rem: 0};
        vecs[3] = '{data: 16'h0003, stall_at: -1, stall_len: 0, rem: 3};
        vecs[4] = '{data: 16'h8001, stall_at: 0,  stall_len: 2, rem: 4};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_new_bit", 32'(new_bit), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check_rem("rst_rem", 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 5; v++)
            run_word(vecs[v].data, vecs[v].stall_at, vecs[v].stall_len, 0,
                     MOD5 ? vecs[v].rem : 0);

        // Back-to-back words with in_valid held high.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        out_ready = 1'b1;
        #1;
        check("b2b_load_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_data = 16'h0005;
        for (int w = 0; w < 2; w++) begin
            d = (w == 0) ? 16'h000A : 16'h0005;
            for (int i = 0; i < W; i++) begin
                if (w == 1 && i == 0) in_valid = 1'b0;
                #1;
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_bit", 32'(new_bit), 32'(d[W-1-i]));
                check("b2b_last", 32'(out_last), 32'(i == W - 1));
                check("b2b_done", 32'(done), 32'(w == 1 && i == 0));
                check("b2b_in_ready", 32'(in_ready), 32'(i == W - 1));
                check_rem("b2b_rem", prefix_rem(d, i));
                @(negedge clk);
            end
        end
        #1;
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_idle", 32'(out_valid), 32'd0);
        check_rem("b2b_rem_end", full_rem(16'h0005));

        // Reset in the middle of a word.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("mid_bit_before_rst", 32'(new_bit), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_new_bit", 32'(new_bit), 32'd0);
        check("arst_out_last", 32'(out_last), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check_rem("arst_rem", 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_done2", 32'(done), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        run_word(16'h8001, -1, 0, 0, full_rem(16'h8001));

        // Random words with random back-pressure.
        for (int k = 0; k < 25; k++) begin
            d = W'($urandom);
            run_word(d, -1, 0, 35, full_rem(d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_number_transmitter.md
SERIAL_NUMBER_TRANSMITTER -- requirements
Module: serial_number_transmitter

Interface
REQ-001 Parameter: W, default 16, word width in bits (W >= 2).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 in_valid  input  1  parallel word offered.
REQ-005 in_ready  output  1  transmitter accepts word this cycle.
REQ-006 in_data  input  W  word to serialize, MSB first.
REQ-007 out_valid  output  1  new_bit is valid.
REQ-008 out_ready  input  1  downstream consumes new_bit this cycle.
REQ-009 new_bit  output  1  current serial bit.
REQ-010 out_last  output  1  current bit is the LSB of the word.
REQ-011 done  output  1  one-cycle pulse after the LSB transfer.
REQ-012 rem5  output  3  running remainder mod 5 of transferred bits (feature-dependent, see Configuration).
REQ-013 div_by_5  output  1  rem5 == 0 (feature-dependent).

Function
REQ-014 FSM states IDLE and SEND; reset state IDLE.
REQ-015 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-016 in_ready = 1 in IDLE, or in SEND during the output transfer of the last bit; otherwise 0.
REQ-017 On input transfer: load shift register with in_data, bit counter to 0, rem5 to 0, next state SEND.
REQ-018 In SEND: out_valid = 1, new_bit = shift register MSB, out_last = (counter == W-1).
REQ-019 In IDLE: out_valid = 0, new_bit = 0, out_last = 0.
REQ-020 On output transfer (not last): shift left by 1, counter + 1, stay in SEND.
REQ-021 On output transfer of last bit without simultaneous input transfer: next state IDLE.
REQ-022 Last bit transfer with simultaneous input transfer: load new word, stay in SEND, no idle bubble.
REQ-023 out_ready = 0 in SEND: new_bit, out_last, counter, shift register, rem5 all hold; out_valid stays 1.
REQ-024 First bit of a loaded word appears one cycle after the input transfer; a word takes exactly W cycles with out_ready held at 1.
REQ-025 done = 1 for exactly the cycle after the last-bit transfer, including in the back-to-back case.
REQ-026 in_data and in_valid are ignored when in_ready = 0.

Reset
REQ-027 rst = 0 forces immediately, without a clock edge: state IDLE, counter 0, shift register 0, rem5 0, done 0, out_valid 0.
REQ-028 Reset mid-word abandons the word; no done pulse follows; the first word after release starts at its MSB.

Configuration
REQ-029 Macro SERIAL_TX_MOD5_EN defined: on each output transfer, rem5 <= (2*rem5 + new_bit) mod 5, and div_by_5 = (rem5 == 0).
REQ-030 SERIAL_TX_MOD5_EN defined: after the last-bit transfer, rem5 equals in_data mod 5 and holds in IDLE until the next input transfer.
REQ-031 SERIAL_TX_MOD5_EN undefined: no remainder logic; rem5 tied to 0, div_by_5 tied to 1.

Structure
REQ-032 Package serial_tx_pkg holds the FSM state enum (IDLE, SEND) and the mod-5 state constants 0..4.
REQ-033 The mod-5 remainder update is a sub-module serial_mod5_step: combinational next-remainder from (rem, bit), instantiated only under SERIAL_TX_MOD5_EN.

Verification
REQ-034 Load 16'hA5A5 with out_ready = 1 -> bits 1010010110100101 on 16 consecutive cycles; out_last on 16th; done next cycle; rem5 = 0, div_by_5 = 1.
REQ-035 Load 16'h0007 -> after last bit rem5 = 2, div_by_5 = 0; intermediate rem5 after bits 14/15/16 = 1/3/2.
REQ-036 Hold out_ready = 0 for 3 cycles after bit 5 of 16'hFFFF -> new_bit, out_last and rem5 stable; total 19 cycles to done.
REQ-037 in_valid held high with 16'h000A then 16'h0005 -> second word's MSB follows first word's LSB with no gap; done pulses twice; rem5 = 0 at each done.
REQ-038 Assert rst = 0 at bit 8 of a word -> outputs reset without clock edge; no done; next word 16'h8001 transmits from MSB.
REQ-039 Build without SERIAL_TX_MOD5_EN -> serial stream identical to REQ-034; rem5 = 0, div_by_5 = 1 throughout.
